// File: rtl/readout_pkg.sv
// Shared definitions for the readout sequencer: state encoding and timing defaults.
package readout_pkg;

  localparam int TMO_CYC_DEF    = 63;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int TMR_W          = 16;

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    RST_REQ,
    RST_WAIT,
    INTEG,
    FREEZE,
    CLR,
    ADC,
    ADC_WAIT,
    MSET,
    MSET_WAIT,
    SETTLE,
    DONE
  } seq_state_e;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with zero flag, shared by integration, timeout and settle timing.
module seq_timer
  import readout_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         CLK,
  input  logic         NRST_X,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  input  logic         DEC,
  output logic         ZERO
);

  logic [W-1:0] cnt;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge CLK or negedge NRST_X) begin
    if (!NRST_X) begin
      cnt <= '0;
    end else if (LOAD) begin
      cnt <= LOAD_VAL;
    end else if (DEC && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign ZERO = (cnt == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Frame sequencer: pixel reset, integration, then ADC readout of each memory in turn.
//
// state     | meaning
// IDLE      | waiting for START
// ARM       | store window opened
// RST_REQ   | one-cycle pixel reset request
// RST_WAIT  | waiting for PIX_END, busy/timeout watch
// INTEG     | integration countdown
// FREEZE    | store window closed
// CLR       | clear memory select
// ADC       | one-cycle conversion request
// ADC_WAIT  | waiting for ADC_ACK
// MSET      | one-cycle memory select advance
// MSET_WAIT | waiting for MEM_SET_DONE, timeout watch
// SETTLE    | settle delay before next conversion
// DONE      | end-of-frame pulse, frame counter bump
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int TMO_CYC    = TMO_CYC_DEF
) (
  input  logic        CLK,
  input  logic        NRST_X,
  input  logic        START,
  input  logic        ABORT,
  input  logic        CONT_MODE,
  input  logic [15:0] INTEG_TIME,
  input  logic        PIX_RESET_BUSY,
  input  logic        PIX_END,
  input  logic        MEM_SET_DONE,
  input  logic        LAST_MEM,
  input  logic        ADC_ACK,
  output logic        PIX_STORE,
  output logic        PIX_RESET,
  output logic        MEM_SET_EN,
  output logic        MEM_SET_CLR,
  output logic        ADC_REQ,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        ERR,
  output logic [15:0] FRAME_CNT
);

  localparam logic [TMR_W-1:0] TMO_LD    = 16'(TMO_CYC);
  // SETTLE is skipped entirely when SETTLE_CYC is 0, so the load value only matters above 0.
  localparam logic [TMR_W-1:0] SETTLE_LD = (SETTLE_CYC > 0) ? 16'(SETTLE_CYC - 1) : 16'd0;

  seq_state_e       state, state_nxt;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic             tmo_err;
  logic [1:0]       busy_win;
  logic             busy_seen;
  logic             busy_miss;
  logic [15:0]      frame_cnt_q;

  assign FRAME_CNT = frame_cnt_q;

  // Third RST_WAIT cycle with no sign of the pixel controller having started.
  assign busy_miss = (busy_win == 2'd0) && !busy_seen && !PIX_RESET_BUSY;

  seq_timer #(.W(TMR_W)) u_timer (
    .CLK      (CLK),
    .NRST_X   (NRST_X),
    .LOAD     (tmr_load),
    .LOAD_VAL (tmr_val),
    .DEC      (tmr_dec),
    .ZERO     (tmr_zero)
  );

  // Next-state decode; ABORT overrides everything and never raises ERR.
  always_comb begin
    state_nxt = state;
    tmo_err   = 1'b0;
    case (state)
      IDLE:      if (START) state_nxt = ARM;
      ARM:       state_nxt = RST_REQ;
      RST_REQ:   state_nxt = RST_WAIT;
      RST_WAIT: begin
        if (PIX_END) begin
          state_nxt = INTEG;
        end else if (tmr_zero || busy_miss) begin
          tmo_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      INTEG:     if (tmr_zero) state_nxt = FREEZE;
      FREEZE:    state_nxt = CLR;
      CLR:       state_nxt = ADC;
      ADC:       state_nxt = ADC_WAIT;
      ADC_WAIT:  if (ADC_ACK) state_nxt = LAST_MEM ? DONE : MSET;
      MSET:      state_nxt = MSET_WAIT;
      MSET_WAIT: begin
        if (MEM_SET_DONE) begin
          state_nxt = (SETTLE_CYC == 0) ? ADC : SETTLE;
        end else if (tmr_zero) begin
          tmo_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      SETTLE:    if (tmr_zero) state_nxt = ADC;
      DONE:      state_nxt = CONT_MODE ? ARM : IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (ABORT) begin
      state_nxt = IDLE;
      tmo_err   = 1'b0;
    end
  end

  // Timer is loaded on entry to a timed state and counts down while the state holds.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    if (state_nxt != state) begin
      case (state_nxt)
        RST_WAIT, MSET_WAIT: begin
          tmr_load = 1'b1;
          tmr_val  = TMO_LD;
        end
        INTEG: begin
          tmr_load = 1'b1;
          tmr_val  = INTEG_TIME;
        end
        SETTLE: begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
        default: ;
      endcase
    end else begin
      tmr_dec = 1'b1;
    end
  end

  // State register with outputs decoded from the next state so they line up with it.
  always_ff @(posedge CLK or negedge NRST_X) begin
    if (!NRST_X) begin
      state       <= IDLE;
      PIX_STORE   <= 1'b0;
      PIX_RESET   <= 1'b0;
      MEM_SET_EN  <= 1'b0;
      MEM_SET_CLR <= 1'b0;
      ADC_REQ     <= 1'b0;
      BUSY        <= 1'b0;
      FRAME_DONE  <= 1'b0;
      ERR         <= 1'b0;
      frame_cnt_q <= 16'd0;
      busy_win    <= 2'd0;
      busy_seen   <= 1'b0;
    end else begin
      state       <= state_nxt;
      PIX_STORE   <= state_nxt inside {ARM, RST_REQ, RST_WAIT, INTEG};
      PIX_RESET   <= (state_nxt == RST_REQ);
      MEM_SET_EN  <= (state_nxt == MSET);
      MEM_SET_CLR <= (state_nxt == CLR);
      ADC_REQ     <= (state_nxt == ADC);
      BUSY        <= (state_nxt != IDLE);
      FRAME_DONE  <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (tmo_err) begin
        ERR <= 1'b1;
      end else if ((state == IDLE) && START && !ABORT) begin
        ERR <= 1'b0;
      end
      if (state != RST_WAIT) begin
        busy_win  <= 2'd2;
        busy_seen <= 1'b0;
      end else begin
        if (busy_win != 2'd0) busy_win <= busy_win - 2'd1;
        if (PIX_RESET_BUSY) busy_seen <= 1'b1;
      end
    end
  end

endmodule
